// File: rtl/rad_async_fifo_rd_arb.sv
// Read-side drain scheduler: round-robin bursts from NCH show-ahead FIFOs onto one
// valid/ready stream, with a single IDLE bubble between grants.
module rad_async_fifo_rd_arb #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         rempty,
    input  logic [NCH*DW-1:0]      rdata,
    output logic [NCH-1:0]         rinc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic                   busy
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] sel_q, sel_d;
    logic [CW-1:0] last_q, last_d;
    logic [BW-1:0] cnt_q, cnt_d;

    logic [NCH-1:0] req;
    logic [DW-1:0]  ch_data [NCH];
    logic [CW-1:0]  cand;
    logic [CW-1:0]  pick;
    logic           found;
    logic           hs;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_data[i] = rdata[i*DW +: DW];
        end
    end

    assign req = en & ~rempty;

    // Search last+1, last+2, ... so the channel just released is considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(last_q) + k) % NCH);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_ch    = '0;
        busy      = 1'b0;
        rinc      = '0;
        hs        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d   = pick;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                busy       = 1'b1;
                out_ch     = sel_q;
                out_data   = ch_data[sel_q];
                out_valid  = !rempty[sel_q];
                hs         = out_valid && out_ready;
                rinc[sel_q] = hs;
                if (hs) begin
                    cnt_d = cnt_q + BW'(1);
                end
                if ((hs && cnt_q == BW'(MAX_BURST - 1)) || !out_valid || (hs && !en[sel_q])) begin
                    state_d = StIdle;
                    last_d  = sel_q;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= CW'(NCH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rad_async_fifo_rd_arb.sv
// Directed bench for rad_async_fifo_rd_arb with a simple show-ahead FIFO model per channel.
module tb_rad_async_fifo_rd_arb;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    rempty;
    logic [NCH*DW-1:0] rdata;
    logic [NCH-1:0]    rinc;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cnt [NCH];
    int ptr [NCH];
    logic [7:0] got_d [$];
    logic [1:0] got_c [$];
    logic [7:0] exp_fair [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                                  8'h22, 8'h23, 8'h24, 8'h25, 8'h30, 8'h31, 8'h32, 8'h33,
                                  8'h04, 8'h05, 8'h06, 8'h07};
    logic [7:0] exp_en [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33,
                                8'h14, 8'h15, 8'h16, 8'h17};

    rad_async_fifo_rd_arb #(.NCH(NCH), .DW(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            rempty[i]         = (cnt[i] == 0);
            rdata[i*DW +: DW] = 8'((i << 4) | (ptr[i] & 15));
        end
    endtask

    task automatic load(input int ch, input int n);
        cnt[ch] = n;
        ptr[ch] = 0;
    endtask

    // One clock: pop whichever FIFO the DUT incremented at the edge, then settle.
    task automatic step();
        logic [NCH-1:0] r;
        r = rinc;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (r[i] && cnt[i] > 0) begin
                cnt[i]--;
                ptr[i]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic record(input int cycles);
        got_d.delete();
        got_c.delete();
        for (int c = 0; c < cycles; c++) begin
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_c.push_back(out_ch);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) load(i, 0);
        drive();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_rinc", rinc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_data", out_data, 0);

        // single channel, three entries
        rst = 1'b0;
        load(2, 3);
        drive();
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_valid", out_valid, 0);
        step();
        chk("t1_b0_valid", out_valid, 1);
        chk("t1_b0_ch", out_ch, 2);
        chk("t1_b0_data", out_data, 8'h20);
        chk("t1_b0_rinc", rinc, 4'b0100);
        step();
        chk("t1_b1_data", out_data, 8'h21);
        step();
        chk("t1_b2_data", out_data, 8'h22);
        step();
        chk("t1_empty_valid", out_valid, 0);
        chk("t1_empty_busy", busy, 1);
        chk("t1_empty_rinc", rinc, 0);
        step();
        chk("t1_idle2_busy", busy, 0);

        // early drain on ch0, then ch1 burst with backpressure
        load(0, 2);
        load(1, 5);
        drive();
        #1;
        step();
        chk("ed_b0_ch", out_ch, 0);
        chk("ed_b0_data", out_data, 8'h00);
        step();
        chk("ed_b1_data", out_data, 8'h01);
        step();
        chk("ed_drain_valid", out_valid, 0);
        chk("ed_drain_busy", busy, 1);
        step();
        chk("ed_idle_busy", busy, 0);
        step();
        chk("ed_next_ch", out_ch, 1);
        chk("ed_next_data", out_data, 8'h10);
        chk("ed_next_rinc", rinc, 4'b0010);
        step();
        chk("bp_b1_data", out_data, 8'h11);
        step();
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 8'h12);
            chk("bp_hold_ch", out_ch, 1);
            chk("bp_hold_rinc", rinc, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_data", out_data, 8'h12);
        chk("bp_resume_rinc", rinc, 4'b0010);
        step();
        chk("bp_b3_data", out_data, 8'h13);
        step();
        chk("bp_release_busy", busy, 0);

        // reset during beat 2 of a ch2 burst
        for (int i = 0; i < NCH; i++) load(i, 10);
        drive();
        #1;
        step();
        chk("rm_b0_ch", out_ch, 2);
        chk("rm_b0_data", out_data, 8'h20);
        step();
        chk("rm_b1_data", out_data, 8'h21);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rm_valid", out_valid, 0);
        chk("rm_rinc", rinc, 0);
        chk("rm_busy", busy, 0);
        step();
        chk("rm_restart_ch", out_ch, 0);

        // fairness across four full channels
        record(25);
        chk("fair_count", got_d.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < got_d.size()) begin
                chk("fair_data", got_d[i], exp_fair[i]);
                chk("fair_ch", got_c[i], exp_fair[i] >> 4);
            end
        end

        // enable mask
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 4'b0000;
        for (int i = 0; i < NCH; i++) load(i, 10);
        drive();
        #1;
        step();
        chk("en0_busy_a", busy, 0);
        step();
        chk("en0_busy_b", busy, 0);
        en = 4'b1010;
        #1;
        step();
        record(15);
        chk("en_count", got_d.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < got_d.size()) begin
                chk("en_data", got_d[i], exp_en[i]);
            end
        end
        chk("en_ch3_ch", out_ch, 3);
        chk("en_ch3_data", out_data, 8'h34);
        en = 4'b0010;
        #1;
        step();
        chk("en_clear_busy", busy, 0);
        step();
        chk("en_after_ch", out_ch, 1);
        chk("en_after_data", out_data, 8'h18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
